shape_raster: RTL and testbench

Parametrised pixel rasteriser between the game-level painters and the video-memory write port. It accepts one shape command per start pulse and emits a pixel stream with a setup/hold-framed write strobe. Shapes are a pixel rectangle, latched at start, filled as a solid rectangle, circle or outline. A start/busy/done handshake replaces fixed cycle-count waiting in the caller, and pixels outside the screen are clipped.

---
 rtl/shape_raster.sv | 210 +++++++++++++++++++++
 tb/tb_shape_raster.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shape_raster.sv
// Shape rasteriser: walks a latched rectangle in row-major order and emits
// a setup/hold-framed pixel write strobe for fill, circle or outline shapes.
module shape_raster #(
  parameter int unsigned X_BITS     = 8,
  parameter int unsigned Y_BITS     = 7,
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned SCR_W      = 160,
  parameter int unsigned SCR_H      = 120,
  parameter int unsigned WRITE_HOLD = 3
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [X_BITS-1:0]     x_start,
  input  logic [X_BITS-1:0]     x_end,
  input  logic [Y_BITS-1:0]     y_start,
  input  logic [Y_BITS-1:0]     y_end,
  input  logic [3:0]            border_w,
  input  logic [COLOR_BITS-1:0] color,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [X_BITS-1:0]     paint_x_co,
  output logic [Y_BITS-1:0]     paint_y_co,
  output logic [COLOR_BITS-1:0] color_output,
  output logic                  print_enable
);

  localparam int unsigned MW  = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int unsigned CW  = MW + 2;
  localparam int unsigned PW  = 2 * CW + 1;
  localparam int unsigned XW1 = X_BITS + 1;
  localparam int unsigned YW1 = Y_BITS + 1;
  localparam int unsigned HW  = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_SETUP, S_WRITE, S_RELEASE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [X_BITS-1:0]     xs_q, xs_d, xe_q, xe_d, cx_q, cx_d, px_q, px_d;
  logic [Y_BITS-1:0]     ys_q, ys_d, ye_q, ye_d, cy_q, cy_d, py_q, py_d;
  logic [1:0]            mode_q, mode_d;
  logic [3:0]            bw_q, bw_d;
  logic [COLOR_BITS-1:0] color_q, color_d, pc_q, pc_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  busy_q, busy_d, done_q, done_d, pe_q, pe_d;

  logic signed [CW-1:0]  dx, dy;
  logic signed [PW-1:0]  dx_e, dy_e, dist_sq, r_sq;
  logic [X_BITS-1:0]     rx;
  logic [Y_BITS-1:0]     ry;
  logic [CW-1:0]         r;
  logic                  in_circle, in_outline, in_shape, clipped;
  logic [XW1-1:0]        x_inc;
  logic [YW1-1:0]        y_inc;
  logic                  row_end, last_pix;
  logic [X_BITS-1:0]     adv_x;
  logic [Y_BITS-1:0]     adv_y;

  // Pixel membership test on the cursor, using doubled coordinates for the circle.
  always_comb begin
    dx        = $signed(CW'({cx_q, 1'b1}) - (CW'(xs_q) + CW'(xe_q)));
    dy        = $signed(CW'({cy_q, 1'b1}) - (CW'(ys_q) + CW'(ye_q)));
    dx_e      = PW'(dx);
    dy_e      = PW'(dy);
    dist_sq   = dx_e * dx_e + dy_e * dy_e;
    rx        = xe_q - xs_q;
    ry        = ye_q - ys_q;
    r         = (CW'(rx) < CW'(ry)) ? CW'(rx) : CW'(ry);
    r_sq      = $signed(PW'(r)) * $signed(PW'(r));
    in_circle = (dist_sq <= r_sq);
    in_outline = (XW1'(cx_q) < XW1'(xs_q) + XW1'(bw_q)) ||
                 (XW1'(cx_q) + XW1'(bw_q) >= XW1'(xe_q)) ||
                 (YW1'(cy_q) < YW1'(ys_q) + YW1'(bw_q)) ||
                 (YW1'(cy_q) + YW1'(bw_q) >= YW1'(ye_q));
    case (mode_q)
      2'b01:   in_shape = in_circle;
      2'b10:   in_shape = in_outline;
      default: in_shape = 1'b1;
    endcase
    clipped  = (32'(cx_q) >= SCR_W) || (32'(cy_q) >= SCR_H);
    x_inc    = XW1'(cx_q) + XW1'(1);
    y_inc    = YW1'(cy_q) + YW1'(1);
    row_end  = (x_inc >= XW1'(xe_q));
    last_pix = row_end && (y_inc >= YW1'(ye_q));
    adv_x    = row_end ? xs_q : x_inc[X_BITS-1:0];
    adv_y    = row_end ? y_inc[Y_BITS-1:0] : cy_q;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    mode_d  = mode_q;
    bw_d    = bw_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            xs_d    = x_start;
            xe_d    = x_end;
            ys_d    = y_start;
            ye_d    = y_end;
            mode_d  = mode;
            bw_d    = border_w;
            color_d = color;
            cx_d    = x_start;
            cy_d    = y_start;
            state_d = (x_end <= x_start || y_end <= y_start) ? S_DONE : S_EVAL;
          end
        end
        S_EVAL: begin
          if (in_shape && !clipped) begin
            px_d    = cx_q;
            py_d    = cy_q;
            pc_d    = color_q;
            hold_d  = '0;
            state_d = S_SETUP;
          end else if (last_pix) begin
            state_d = S_DONE;
          end else begin
            cx_d = adv_x;
            cy_d = adv_y;
          end
        end
        S_SETUP: state_d = S_WRITE;
        S_WRITE: begin
          if (hold_q == HW'(WRITE_HOLD - 1)) state_d = S_RELEASE;
          else hold_d = hold_q + HW'(1);
        end
        S_RELEASE: begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            cx_d    = adv_x;
            cy_d    = adv_y;
            state_d = S_EVAL;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    pe_d   = (state_d == S_WRITE);
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
      mode_q  <= '0;
      bw_q    <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      mode_q  <= mode_d;
      bw_q    <= bw_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pe_q    <= pe_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign print_enable = pe_q;
  assign paint_x_co   = px_q;
  assign paint_y_co   = py_q;
  assign color_output = pc_q;

endmodule

// File: tb/tb_shape_raster.sv
// Self-checking bench for shape_raster: a per-cycle expected-output queue built
// from the shape rules and pixel timing, compared every falling clock edge.
module tb_shape_raster;
  localparam int H = 3;

  logic       Clck = 1'b0;
  logic       Reset, start, abort;
  logic [1:0] mode;
  logic [7:0] x_start, x_end;
  logic [6:0] y_start, y_end;
  logic [3:0] border_w;
  logic [2:0] color;
  logic       busy, done, print_enable;
  logic [7:0] paint_x_co;
  logic [6:0] paint_y_co;
  logic [2:0] color_output;

  shape_raster dut (
    .Clck(Clck), .Reset(Reset), .start(start), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .border_w(border_w), .color(color), .abort(abort),
    .busy(busy), .done(done), .paint_x_co(paint_x_co), .paint_y_co(paint_y_co),
    .color_output(color_output), .print_enable(print_enable)
  );

  always #5 Clck = ~Clck;

  typedef struct {
    bit busy; bit done; bit pe; int x; int y; int c;
  } ent_t;

  ent_t exp_q[$];
  int   mdl_x = 0, mdl_y = 0, mdl_c = 0;
  bit   chk_en = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   dut_writes = 0, dut_dones = 0;
  bit   pe_prev = 1'b0;

  function automatic bit pix_on(int m, int xs, int xe, int ys, int ye, int bw, int x, int y);
    int dx, dy, r;
    if (x >= 160 || y >= 120) return 1'b0;
    dx = 2 * x + 1 - (xs + xe);
    dy = 2 * y + 1 - (ys + ye);
    r  = (xe - xs < ye - ys) ? xe - xs : ye - ys;
    case (m)
      1:       return (dx * dx + dy * dy <= r * r);
      2:       return (x < xs + bw) || (x >= xe - bw) || (y < ys + bw) || (y >= ye - bw);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int count_on(int m, int xs, int xe, int ys, int ye, int bw);
    int n = 0;
    for (int y = ys; y < ye; y++)
      for (int x = xs; x < xe; x++)
        if (pix_on(m, xs, xe, ys, ye, bw, x, y)) n++;
    return n;
  endfunction

  task automatic push(bit b, bit d, bit p, int x, int y, int c);
    ent_t e;
    e = '{busy: b, done: d, pe: p, x: x, y: y, c: c};
    exp_q.push_back(e);
  endtask

  // Expected per-cycle outputs: idle cycle while start is sampled, then pixels, then DONE.
  task automatic build(int m, int xs, int xe, int ys, int ye, int bw, int c);
    push(0, 0, 0, mdl_x, mdl_y, mdl_c);
    if (xe > xs && ye > ys) begin
      for (int y = ys; y < ye; y++)
        for (int x = xs; x < xe; x++) begin
          push(1, 0, 0, mdl_x, mdl_y, mdl_c);
          if (pix_on(m, xs, xe, ys, ye, bw, x, y)) begin
            mdl_x = x; mdl_y = y; mdl_c = c;
            push(1, 0, 0, x, y, c);
            for (int k = 0; k < H; k++) push(1, 0, 1, x, y, c);
            push(1, 0, 0, x, y, c);
          end
        end
    end
    push(1, 1, 0, mdl_x, mdl_y, mdl_c);
  endtask

  task automatic chk(string name, int got, int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  always @(negedge Clck) begin
    ent_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{busy: 0, done: 0, pe: 0, x: mdl_x, y: mdl_y, c: mdl_c};
      n_chk++;
      if (busy === e.busy && done === e.done && print_enable === e.pe &&
          int'(paint_x_co) == e.x && int'(paint_y_co) == e.y && int'(color_output) == e.c)
        n_pass++;
      else
        $display("FAIL cycle t=%0t got b%b d%b pe%b (%0d,%0d) c%0d want b%b d%b pe%b (%0d,%0d) c%0d",
                 $time, busy, done, print_enable, paint_x_co, paint_y_co, color_output,
                 e.busy, e.done, e.pe, e.x, e.y, e.c);
      if (print_enable && !pe_prev) dut_writes++;
      if (done) dut_dones++;
      pe_prev = print_enable;
    end
  end

  // abort_at / reset_at: cycle offset after the start cycle; -2 picks a random abort point.
  task automatic run_cmd(int m, int xs, int xe, int ys, int ye, int bw, int c,
                         bit hold_start, bit scramble, int abort_at, int reset_at);
    ent_t e0;
    bit   fin = 1'b0;
    @(posedge Clck); #1;
    mode = 2'(m); x_start = 8'(xs); x_end = 8'(xe); y_start = 7'(ys); y_end = 7'(ye);
    border_w = 4'(bw); color = 3'(c); start = 1'b1;
    build(m, xs, xe, ys, ye, bw, c);
    if (abort_at == -2) abort_at = (exp_q.size() >= 3) ? $urandom_range(1, exp_q.size() - 2) : -1;
    for (int k = 1; k < 3000; k++) begin
      @(posedge Clck); #1;
      abort = 1'b0;
      Reset = 1'b0;
      if (k == abort_at) begin
        abort = 1'b1;
        e0 = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e0);
        push(1, 1, 0, e0.x, e0.y, e0.c);
        mdl_x = e0.x; mdl_y = e0.y; mdl_c = e0.c;
      end
      if (k == reset_at) begin
        Reset = 1'b1;
        e0 = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e0);
        push(0, 0, 0, 0, 0, 0);
        mdl_x = 0; mdl_y = 0; mdl_c = 0;
      end
      start = hold_start && exp_q.size() > 0 && !exp_q[0].done;
      if (scramble) begin
        mode = 2'($urandom); x_start = 8'($urandom); x_end = 8'($urandom);
        y_start = 7'($urandom); y_end = 7'($urandom);
        border_w = 4'($urandom); color = 3'($urandom);
      end
      if (exp_q.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; Reset = 1'b0;
    if (!fin) begin
      n_chk++;
      $display("FAIL cmd_timeout queue left %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  int w0, d0;

  initial begin
    Reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0;
    x_start = '0; x_end = '0; y_start = '0; y_end = '0; border_w = '0; color = '0;
    repeat (3) @(posedge Clck);
    #1 Reset = 1'b0;
    chk_en = 1'b1;
    @(negedge Clck); #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_pe", int'(print_enable), 0);
    chk("reset_x", int'(paint_x_co), 0);

    chk("model_fill", count_on(0, 2, 4, 3, 5, 0), 4);
    chk("model_circle", count_on(1, 0, 8, 0, 8, 0), 52);
    chk("model_corner", int'(pix_on(1, 0, 8, 0, 8, 0, 0, 0)), 0);
    chk("model_outline", count_on(2, 10, 15, 10, 14, 1), 14);
    chk("model_outline_bw0", count_on(2, 10, 15, 10, 14, 0), 0);
    chk("model_clip", count_on(0, 158, 162, 0, 1, 0), 2);

    w0 = dut_writes; d0 = dut_dones;
    run_cmd(0, 2, 4, 3, 5, 0, 5, 0, 0, -1, -1);
    chk("fill_writes", dut_writes - w0, 4);
    chk("fill_dones", dut_dones - d0, 1);

    w0 = dut_writes;
    run_cmd(1, 0, 8, 0, 8, 0, 6, 0, 0, -1, -1);
    chk("circle_writes", dut_writes - w0, 52);

    w0 = dut_writes;
    run_cmd(2, 10, 15, 10, 14, 1, 3, 0, 0, -1, -1);
    chk("outline_writes", dut_writes - w0, 14);

    w0 = dut_writes; d0 = dut_dones;
    run_cmd(2, 10, 15, 10, 14, 0, 3, 0, 0, -1, -1);
    chk("outline_bw0_writes", dut_writes - w0, 0);
    chk("outline_bw0_dones", dut_dones - d0, 1);

    w0 = dut_writes;
    run_cmd(3, 158, 162, 0, 1, 0, 7, 0, 0, -1, -1);
    chk("clip_writes", dut_writes - w0, 2);

    w0 = dut_writes; d0 = dut_dones;
    run_cmd(0, 0, 4, 0, 1, 0, 2, 0, 0, 1 + 2 * (H + 3) + 3, -1);
    chk("abort_writes", dut_writes - w0, 3);
    chk("abort_dones", dut_dones - d0, 1);

    w0 = dut_writes;
    run_cmd(0, 2, 4, 3, 5, 0, 1, 1, 1, -1, -1);
    chk("after_abort_hold_start_writes", dut_writes - w0, 4);

    w0 = dut_writes; d0 = dut_dones;
    run_cmd(0, 5, 7, 5, 6, 0, 4, 0, 0, -1, 4);
    chk("reset_mid_write_writes", dut_writes - w0, 1);
    chk("reset_mid_write_dones", dut_dones - d0, 0);

    w0 = dut_writes; d0 = dut_dones;
    run_cmd(0, 5, 5, 5, 9, 0, 4, 0, 0, -1, -1);
    chk("degenerate_writes", dut_writes - w0, 0);
    chk("degenerate_dones", dut_dones - d0, 1);

    for (int i = 0; i < 40; i++) begin
      int xs, ys, xe, ye;
      xs = $urandom_range(0, 170);
      ys = $urandom_range(0, 125);
      xe = xs + $urandom_range(0, 6);
      ye = ys + $urandom_range(0, 5);
      if (xe > 255) xe = 255;
      if (ye > 127) ye = 127;
      run_cmd($urandom_range(0, 3), xs, xe, ys, ye, $urandom_range(0, 3), $urandom_range(0, 7),
              1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? -2 : -1, -1);
    end

    repeat (3) @(posedge Clck);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
